// File: rtl/sam_pkg.sv
// Shared SAM definitions: bus widths, rw encoding and memory
// handshake states, reused by the datapath and controller.
package sam_pkg;

    localparam int SAM_ADDR_W = 16;
    localparam int SAM_DATA_W = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } sam_mem_state_t;

endpackage

// File: rtl/sam_memory_if.sv
// SAM memory port: request/wait handshake between the SAM datapath
// (master) and main memory (slave).
interface sam_memory_if
    import sam_pkg::*;
#(
    parameter int ADDR_W = SAM_ADDR_W,
    parameter int DATA_W = SAM_DATA_W
);
    logic [ADDR_W-1:0] addr;
    logic              request;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              wait_o;
    logic              err;

    modport master (
        output addr,
        output request,
        output rw,
        output wr_data,
        input  rd_data,
        input  wait_o,
        input  err
    );

    modport slave (
        input  addr,
        input  request,
        input  rw,
        input  wr_data,
        output rd_data,
        output wait_o,
        output err
    );
endinterface

// File: rtl/sam_memory_array.sv
// Single-port word RAM: synchronous write, registered synchronous read.
// Holds its last read word until the next read strobe.
module sam_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        if (re) begin
            rdata <= mem[index];
        end
    end
endmodule

// File: rtl/sam_memory.sv
// SAM main memory: request/wait handshake with a fixed number of
// wait states in front of a single-port word array.
module sam_memory
    import sam_pkg::*;
#(
    parameter int ADDR_W      = SAM_ADDR_W,
    parameter int DATA_W      = SAM_DATA_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
    sam_memory_if.slave  bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);

    sam_mem_state_t    state_q;
    sam_mem_state_t    state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic [ADDR_W-2:0] idx_q;
    logic              rw_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_sel_q;
    logic              err_q;

    logic              commit;
    logic              latch;
    logic [ADDR_W-2:0] acc_idx;
    logic              acc_rw;
    logic [DATA_W-1:0] acc_wdata;
    logic              in_range;
    logic              arr_we;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    // Words are 16-bit, so the byte-select bit never matters.
    logic unused_addr0;
    assign unused_addr0 = bus.addr[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        latch     = 1'b0;
        acc_idx   = idx_q;
        acc_rw    = rw_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            IDLE: begin
                // Zero wait states commit straight from the live bus.
                acc_idx   = bus.addr[ADDR_W-1:1];
                acc_rw    = bus.rw;
                acc_wdata = bus.wr_data;
                if (bus.request) begin
                    latch = 1'b1;
                    cnt_d = WAIT_N;
                    if (WAIT_N == 4'd0) begin
                        commit  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q <= 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = bus.request ? RELEASE : IDLE;
            end
            RELEASE: begin
                if (!bus.request) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_range = ({2'b00, acc_idx} < DEPTH_L);
    assign arr_we   = commit && !rst && (acc_rw == RW_WRITE) && in_range;
    assign arr_re   = commit && !rst && (acc_rw == RW_READ) && in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            rw_q     <= RW_READ;
            wdata_q  <= '0;
            rd_sel_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                idx_q   <= acc_idx;
                rw_q    <= acc_rw;
                wdata_q <= acc_wdata;
            end
            err_q <= commit && !in_range;
            // An out-of-range read presents zero instead of the array word.
            if (commit && acc_rw == RW_READ) begin
                rd_sel_q <= in_range;
            end
        end
    end

    sam_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .index (acc_idx[IDX_W-1:0]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    assign bus.rd_data = rd_sel_q ? arr_rdata : '0;
    assign bus.err     = err_q;
    assign bus.wait_o  = !rst &&
                         ((state_q == IDLE && bus.request) || state_q == BUSY);
endmodule

// File: tb/tb_sam_memory.sv
// Directed bench for sam_memory: one instance with three wait states,
// one with zero wait states, sharing clock and reset.
module tb_sam_memory;
    import sam_pkg::*;

    logic clk;
    logic rst;
    int   n_asrt;
    int   n_fail;
    int   wc;
    logic ev;

    sam_memory_if bus3 ();
    sam_memory_if bus0 ();

    sam_memory #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    sam_memory #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic q, input logic r,
                         input logic [15:0] a, input logic [15:0] d);
        if (sel) begin
            bus0.request = q;
            bus0.rw      = r;
            bus0.addr    = a;
            bus0.wr_data = d;
        end else begin
            bus3.request = q;
            bus3.rw      = r;
            bus3.addr    = a;
            bus3.wr_data = d;
        end
    endtask

    // One access: counts wait_o-high cycles, returns err seen in DONE.
    task automatic access(input bit sel, input logic r,
                          input logic [15:0] a, input logic [15:0] d,
                          output int wcnt, output logic errv);
        @(posedge clk);
        #1;
        drive(sel, 1'b1, r, a, d);
        wcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel ? bus0.wait_o : bus3.wait_o) wcnt++;
            else break;
        end
        errv = sel ? bus0.err : bus3.err;
        drive(sel, 1'b0, r, a, d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, RW_READ, 16'h0, 16'h0);
        drive(1'b1, 1'b0, RW_READ, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", bus3.rd_data, 16'h0000);
        chk("reset_err", bus3.err, 1'b0);
        chk("reset_state", dut3.state_q, IDLE);
        bus3.request = 1'b1;
        #1;
        chk("reset_wait_forced", bus3.wait_o, 1'b0);
        bus3.request = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        access(1'b0, RW_WRITE, 16'h0010, 16'hBEEF, wc, ev);
        chk("wr_wait_cycles", wc, 4);
        chk("wr_err", ev, 1'b0);
        access(1'b0, RW_READ, 16'h0010, 16'h0, wc, ev);
        chk("rd_wait_cycles", wc, 4);
        chk("rd_data_beef", bus3.rd_data, 16'hBEEF);
        chk("rd_err", ev, 1'b0);

        access(1'b0, RW_WRITE, 16'h0021, 16'h1234, wc, ev);
        access(1'b0, RW_READ, 16'h0020, 16'h0, wc, ev);
        chk("odd_addr_rd", bus3.rd_data, 16'h1234);

        access(1'b0, RW_WRITE, 16'h0000, 16'h0F0F, wc, ev);
        access(1'b0, RW_WRITE, 16'h0800, 16'h5555, wc, ev);
        chk("oor_wr_err", ev, 1'b1);
        chk("oor_err_one_cycle", bus3.err, 1'b0);
        access(1'b0, RW_READ, 16'h0000, 16'h0, wc, ev);
        chk("oor_wr_no_alias", bus3.rd_data, 16'h0F0F);
        access(1'b0, RW_READ, 16'h0010, 16'h0, wc, ev);
        chk("oor_wr_keep_beef", bus3.rd_data, 16'hBEEF);
        access(1'b0, RW_READ, 16'h0800, 16'h0, wc, ev);
        chk("oor_rd_zero", bus3.rd_data, 16'h0000);
        chk("oor_rd_err", ev, 1'b1);

        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, RW_READ, 16'h0010, 16'h0);
        wc = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus3.wait_o) wc++;
        end
        chk("held_wait_cycles", wc, 4);
        chk("held_state", dut3.state_q, RELEASE);
        chk("held_rd", bus3.rd_data, 16'hBEEF);
        drive(1'b0, 1'b0, RW_READ, 16'h0010, 16'h0);
        @(posedge clk);
        #1;
        chk("held_idle", dut3.state_q, IDLE);

        access(1'b0, RW_WRITE, 16'h0004, 16'h7777, wc, ev);
        access(1'b0, RW_READ, 16'h0010, 16'h0, wc, ev);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, RW_WRITE, 16'h0004, 16'hAAAA);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rstmid_busy", dut3.state_q, BUSY);
        rst = 1'b1;
        #1;
        chk("rstmid_wait", bus3.wait_o, 1'b0);
        chk("rstmid_rd", bus3.rd_data, 16'h0000);
        chk("rstmid_state", dut3.state_q, IDLE);
        drive(1'b0, 1'b0, RW_READ, 16'h0004, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        access(1'b0, RW_READ, 16'h0004, 16'h0, wc, ev);
        chk("rstmid_keep_7777", bus3.rd_data, 16'h7777);
        chk("rstmid_rd_wait", wc, 4);

        access(1'b1, RW_WRITE, 16'h0000, 16'h1111, wc, ev);
        chk("w0_wr_wait", wc, 1);
        access(1'b1, RW_WRITE, 16'h0002, 16'h2222, wc, ev);
        access(1'b1, RW_READ, 16'h0000, 16'h0, wc, ev);
        chk("w0_rd0_wait", wc, 1);
        chk("w0_rd0", bus0.rd_data, 16'h1111);
        access(1'b1, RW_READ, 16'h0002, 16'h0, wc, ev);
        chk("w0_rd2_wait", wc, 1);
        chk("w0_rd2", bus0.rd_data, 16'h2222);
        chk("w0_err", ev, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end
endmodule
